xadac_vrf_sb: RTL and testbench

//  Per-register scoreboard that sequences execute requests into the vector register file path.

---
 rtl/xadac_vrf_sb.sv | 142 ++++++++++++++
 tb/tb_xadac_vrf_sb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/xadac_vrf_sb.sv
// Purpose : per-register write scoreboard; holds back requests with RAW hazards or a full WAW counter.
// Latency : zero-cycle combinational pass from req_* to iss_*; counter updates land at the next edge.
// Backpressure: req_ready follows iss_ready unless a hazard or flush is present; nothing is buffered.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/req_ready        upstream handshake; req_vs_id/req_vs_use/req_vd_id/req_vd_write describe the request
//   iss_valid/iss_ready        downstream (VRF read stage) handshake
//   wb_fire/wb_vd_id/wb_vd_write  accepted execute response, releases one outstanding write
//   flush                      drops all outstanding state at the next edge
//   busy, err_underflow, stall_cycles  status: any write pending, sticky release-without-write, stall count
//
// Optional feature macro: XADAC_VRF_SB_BYPASS_EN
//   When defined, a same-cycle write-back is subtracted from the count before the hazard check,
//   so a stalled request can issue in the write-back cycle. Otherwise release is seen one cycle later.
module xadac_vrf_sb #(
  parameter int NoRegs = 32,
  parameter int NoVs   = 3,
  parameter int RegIdW = $clog2(NoRegs),
  parameter int CntW   = 2,
  parameter int StallW = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NoVs*RegIdW-1:0] req_vs_id,
  input  logic [NoVs-1:0]        req_vs_use,
  input  logic [RegIdW-1:0]      req_vd_id,
  input  logic                   req_vd_write,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  input  logic                   wb_fire,
  input  logic [RegIdW-1:0]      wb_vd_id,
  input  logic                   wb_vd_write,
  input  logic                   flush,
  output logic                   busy,
  output logic                   err_underflow,
  output logic [StallW-1:0]      stall_cycles
);

  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  logic [CntW-1:0]   cnt_q   [NoRegs];
  logic [CntW-1:0]   cnt_d   [NoRegs];
  logic [CntW-1:0]   cnt_haz [NoRegs];
  logic [NoRegs-1:0] inc_vec;
  logic [NoRegs-1:0] dec_vec;
  logic              err_underflow_q, err_underflow_d;
  logic [StallW-1:0] stall_cycles_q, stall_cycles_d;
  logic              wb_dec;
  logic              hazard;
  logic              issue;

  // Counts seen by the hazard check. With bypass, a write-back landing this
  // cycle already frees its slot; a zero count is never taken below zero.
  always_comb begin
    wb_dec = wb_fire & wb_vd_write;
    for (int r = 0; r < NoRegs; r++) begin
      cnt_haz[r] = cnt_q[r];
`ifdef XADAC_VRF_SB_BYPASS_EN
      if (wb_dec && (wb_vd_id == RegIdW'(r)) && (cnt_q[r] != '0)) begin
        cnt_haz[r] = cnt_q[r] - CntW'(1);
      end
`endif
    end
  end

  // RAW on any used source, or no room left to track another write to vd.
  always_comb begin
    hazard = req_vd_write && (cnt_haz[req_vd_id] == CntMax);
    for (int i = 0; i < NoVs; i++) begin
      if (req_vs_use[i] && (cnt_haz[req_vs_id[i*RegIdW +: RegIdW]] != '0)) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    iss_valid = rstn & req_valid & ~hazard & ~flush;
    req_ready = rstn & iss_ready & ~hazard & ~flush;
    issue     = iss_valid & iss_ready;
  end

  always_comb begin
    inc_vec         = '0;
    dec_vec         = '0;
    err_underflow_d = err_underflow_q;
    for (int r = 0; r < NoRegs; r++) begin
      inc_vec[r] = issue && req_vd_write && (req_vd_id == RegIdW'(r));
      dec_vec[r] = wb_dec && (wb_vd_id == RegIdW'(r));
      cnt_d[r]   = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CntW'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        // A release with nothing outstanding is a protocol error; hold at zero.
        if (cnt_q[r] == '0) begin
          err_underflow_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CntW'(1);
        end
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (req_valid && hazard && !flush && (stall_cycles_q != {StallW{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + StallW'(1);
    end
  end

  // busy reflects registered counts only.
  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NoRegs; r++) begin
      if (cnt_q[r] != '0) begin
        busy = 1'b1;
      end
    end
  end

  assign err_underflow = err_underflow_q;
  assign stall_cycles  = stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NoRegs; r++) begin
        cnt_q[r] <= '0;
      end
      err_underflow_q <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      cnt_q           <= cnt_d;
      err_underflow_q <= err_underflow_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_xadac_vrf_sb.sv
module tb_xadac_vrf_sb;

`ifdef XADAC_VRF_SB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_vs_id;
  logic [2:0]  req_vs_use;
  logic [4:0]  req_vd_id;
  logic        req_vd_write;
  logic        iss_valid;
  logic        iss_ready;
  logic        wb_fire;
  logic [4:0]  wb_vd_id;
  logic        wb_vd_write;
  logic        flush;
  logic        busy;
  logic        err_underflow;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  xadac_vrf_sb dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs_id(req_vs_id), .req_vs_use(req_vs_use),
    .req_vd_id(req_vd_id), .req_vd_write(req_vd_write),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .wb_fire(wb_fire), .wb_vd_id(wb_vd_id), .wb_vd_write(wb_vd_write),
    .flush(flush), .busy(busy), .err_underflow(err_underflow),
    .stall_cycles(stall_cycles)
  );

  task automatic idle();
    req_valid = 0; req_vs_id = '0; req_vs_use = '0; req_vd_id = '0; req_vd_write = 0;
    iss_ready = 1; wb_fire = 0; wb_vd_id = '0; wb_vd_write = 0; flush = 0;
  endtask

  task automatic wr_req(input logic [4:0] vd);
    idle(); req_valid = 1; req_vd_id = vd; req_vd_write = 1;
  endtask

  task automatic wb(input logic [4:0] vd);
    wb_fire = 1; wb_vd_id = vd; wb_vd_write = 1;
  endtask

  task automatic test_reset();
    rstn = 0; idle();
    req_valid = 1; req_vs_use = 3'b001; req_vs_id = {5'd0, 5'd0, 5'd3};
    @(negedge clk); #1;
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL rst_iss_valid: got %0b expected 0", iss_valid); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %0b expected 0", req_ready); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b expected 0", err_underflow); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_stall: got %0d expected 0", stall_cycles); end
    rstn = 1; #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL rst_pass_valid: got %0b expected 1", iss_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_pass_ready: got %0b expected 1", req_ready); end
    @(negedge clk); idle();
  endtask

  task automatic test_raw_stall();
    @(negedge clk); wr_req(5'd5); #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL raw_wr_issue: got %0b expected 1", iss_valid); end
    @(negedge clk); idle(); req_valid = 1; req_vs_use = 3'b001; req_vs_id = {5'd0, 5'd0, 5'd5}; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL raw_busy: got %0b expected 1", busy); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_ready: got %0b expected 0", req_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      exp_stall++;
      checks++; if (stall_cycles !== 16'(exp_stall)) begin failures++; $display("FAIL raw_stall_cnt: got %0d expected %0d", stall_cycles, exp_stall); end
      checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL raw_stall_valid: got %0b expected 0", iss_valid); end
    end
    wb(5'd5); #1;
    checks++; if (iss_valid !== Byp) begin failures++; $display("FAIL raw_wb_cycle_valid: got %0b expected %0b", iss_valid, Byp); end
    if (!Byp) exp_stall++;
    @(negedge clk); wb_fire = 0; wb_vd_write = 0; #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL raw_after_wb_valid: got %0b expected 1", iss_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL raw_after_wb_busy: got %0b expected 0", busy); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin failures++; $display("FAIL raw_final_stall: got %0d expected %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle();
  endtask

  task automatic test_waw_capacity();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); wr_req(5'd7); #1;
      checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL waw_issue%0d: got %0b expected 1", k, iss_valid); end
    end
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL waw_full_ready: got %0b expected 0", req_ready); end
    exp_stall++;
    @(negedge clk); wb(5'd7); #1;
    checks++; if (iss_valid !== Byp) begin failures++; $display("FAIL waw_wb_cycle_valid: got %0b expected %0b", iss_valid, Byp); end
    if (!Byp) exp_stall++;
    @(negedge clk); wb_fire = 0; wb_vd_write = 0;
    if (!Byp) begin
      #1;
      checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL waw_late_issue: got %0b expected 1", iss_valid); end
      @(negedge clk);
    end
    idle(); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL waw_busy: got %0b expected 1", busy); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin failures++; $display("FAIL waw_stall: got %0d expected %0d", stall_cycles, exp_stall); end
    wb(5'd7);
    @(negedge clk); @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL waw_drain_busy: got %0b expected 1", busy); end
    @(negedge clk); idle(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL waw_drained_busy: got %0b expected 0", busy); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL waw_err: got %0b expected 0", err_underflow); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk); wr_req(5'd2); #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL same_first_issue: got %0b expected 1", iss_valid); end
    @(negedge clk); wb(5'd2); #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL same_second_issue: got %0b expected 1", iss_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL same_busy: got %0b expected 1", busy); end
    wb(5'd2);
    @(negedge clk); idle(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL same_release_busy: got %0b expected 0", busy); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL same_err: got %0b expected 0", err_underflow); end
  endtask

  task automatic test_underflow();
    @(negedge clk); idle(); wb(5'd9); #1;
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_before: got %0b expected 0", err_underflow); end
    @(negedge clk); idle(); #1;
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set: got %0b expected 1", err_underflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL uf_busy: got %0b expected 0", busy); end
    wr_req(5'd9); #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL uf_reissue: got %0b expected 1", iss_valid); end
    @(negedge clk); idle(); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL uf_cnt_one: got %0b expected 1", busy); end
    wb(5'd9);
    @(negedge clk); idle(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL uf_cnt_zero: got %0b expected 0", busy); end
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky: got %0b expected 1", err_underflow); end
  endtask

  task automatic test_flush();
    @(negedge clk); wr_req(5'd1);
    @(negedge clk); wr_req(5'd1);
    @(negedge clk); wr_req(5'd4);
    @(negedge clk); idle();
    flush = 1; req_valid = 1; req_vd_id = 5'd4; req_vd_write = 1;
    req_vs_use = 3'b001; req_vs_id = {5'd0, 5'd0, 5'd1}; wb(5'd4); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy: got %0b expected 1", busy); end
    checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL flush_iss_valid: got %0b expected 0", iss_valid); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_req_ready: got %0b expected 0", req_ready); end
    @(negedge clk); flush = 0; wb_fire = 0; wb_vd_write = 0; req_vd_write = 0;
    req_vs_use = 3'b011; req_vs_id = {5'd0, 5'd4, 5'd1}; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %0b expected 0", busy); end
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL flush_cleared: got %0b expected 1", iss_valid); end
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL flush_keeps_err: got %0b expected 1", err_underflow); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin failures++; $display("FAIL flush_stall: got %0d expected %0d", stall_cycles, exp_stall); end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); wr_req(5'd6); #1;
    checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL mid_issue: got %0b expected 1", iss_valid); end
    @(negedge clk); idle(); rstn = 0; #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy: got %0b expected 1", busy); end
    @(negedge clk); rstn = 1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL mid_err: got %0b expected 0", err_underflow); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL mid_stall: got %0d expected 0", stall_cycles); end
    wb(5'd6);
    @(negedge clk); idle(); #1;
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL mid_late_wb_err: got %0b expected 1", err_underflow); end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_waw_capacity();
    test_same_cycle();
    test_underflow();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
